// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared types and widths for the counter job sequencer
package cnt_pkg;

  localparam int CNT_WIDTH_DEF = 7;
  localparam int JOBS_DONE_W   = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RUN  = 2'd2,
    WAIT_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/cnt_job_sequencer_if.sv
// rtl/cnt_job_sequencer_if.sv - job intake and responder start/run/done signals
interface cnt_job_sequencer_if import cnt_pkg::*; #(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
);

  logic                 job_valid_i;
  logic [CNT_WIDTH-1:0] job_val_i;
  logic                 job_ready_o;
  logic                 start_o;
  logic [CNT_WIDTH-1:0] cnt_val_o;
  logic                 run_i;
  logic                 done_i;

  // master is the sequencer; slave is the job source plus responder
  modport master (
    input  job_valid_i, job_val_i, run_i, done_i,
    output job_ready_o, start_o, cnt_val_o
  );

  modport slave (
    output job_valid_i, job_val_i, run_i, done_i,
    input  job_ready_o, start_o, cnt_val_o
  );

endinterface

// File: rtl/cnt_job_fifo.sv
// rtl/cnt_job_fifo.sv - small synchronous job FIFO, full/empty decoded from a count register
module cnt_job_fifo import cnt_pkg::*; #(
  parameter int WIDTH = CNT_WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  // no full-bypass: a pop never frees room for a same-cycle push
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/cnt_job_sequencer.sv
// rtl/cnt_job_sequencer.sv - issues queued count jobs to a start/run/done responder
module cnt_job_sequencer import cnt_pkg::*; #(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int DEPTH     = 4,
  parameter int TO_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  cnt_job_sequencer_if.master    bus,
  output logic                   busy_o,
  output logic                   cmpl_o,
  output logic                   err_o,
  output logic [JOBS_DONE_W-1:0] jobs_done_o
);

  localparam int WD_W = $clog2(TO_CYCLES + 1);

  seq_state_e             state_q, state_d;
  logic                   start_q, start_d;
  logic [CNT_WIDTH-1:0]   cnt_val_q, cnt_val_d;
  logic                   busy_q, busy_d;
  logic                   cmpl_q, cmpl_d;
  logic                   err_q, err_d;
  logic [JOBS_DONE_W-1:0] jobs_done_q, jobs_done_d;
  logic [WD_W-1:0]        wd_q, wd_d, wd_inc;
  logic                   wd_expire;

  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [CNT_WIDTH-1:0]   fifo_head;

  assign fifo_pop = (state_q == IDLE) & ~fifo_empty;

  cnt_job_fifo #(
    .WIDTH (CNT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.job_valid_i),
    .din_i   (bus.job_val_i),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.job_ready_o = ~fifo_full;
  assign bus.start_o     = start_q;
  assign bus.cnt_val_o   = cnt_val_q;
  assign busy_o          = busy_q;
  assign cmpl_o          = cmpl_q;
  assign err_o           = err_q;
  assign jobs_done_o     = jobs_done_q;

  // expiry fires when the count reaches TO_CYCLES, i.e. TO_CYCLES cycles after WAIT_RUN entry
  assign wd_inc    = wd_q + WD_W'(1);
  assign wd_expire = (wd_inc == WD_W'(TO_CYCLES));

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    cnt_val_d   = cnt_val_q;
    cmpl_d      = 1'b0;
    err_d       = 1'b0;
    jobs_done_d = jobs_done_q;
    wd_d        = wd_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          // a zero count would make the responder wrap through its full range
          if (fifo_head != '0) begin
            cnt_val_d = fifo_head;
            start_d   = 1'b1;
            wd_d      = '0;
            state_d   = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_RUN;
      end
      WAIT_RUN, WAIT_DONE: begin
        wd_d = wd_inc;
        if (bus.done_i) begin
          cmpl_d      = 1'b1;
          jobs_done_d = jobs_done_q + JOBS_DONE_W'(1);
          state_d     = IDLE;
        end else if (wd_expire) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (state_q == WAIT_RUN && bus.run_i) begin
          state_d = WAIT_DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      cnt_val_q   <= '0;
      busy_q      <= 1'b0;
      cmpl_q      <= 1'b0;
      err_q       <= 1'b0;
      jobs_done_q <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      cnt_val_q   <= cnt_val_d;
      busy_q      <= busy_d;
      cmpl_q      <= cmpl_d;
      err_q       <= err_d;
      jobs_done_q <= jobs_done_d;
      wd_q        <= wd_d;
    end
  end

endmodule

// File: tb/tb_cnt_job_sequencer.sv
// tb/tb_cnt_job_sequencer.sv - directed bench for cnt_job_sequencer with a modelled responder
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s observed=%0d expected=%0d", tag, (obs), (exp)); \
    end \
  end

module tb_cnt_job_sequencer;

  localparam int W = 7;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy_o, cmpl_o, err_o;
  logic [15:0] jobs_done_o;

  always #5 clk = ~clk;

  cnt_job_sequencer_if #(.CNT_WIDTH(W)) bus ();

  cnt_job_sequencer #(
    .CNT_WIDTH (W),
    .DEPTH     (4),
    .TO_CYCLES (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy_o      (busy_o),
    .cmpl_o      (cmpl_o),
    .err_o       (err_o),
    .jobs_done_o (jobs_done_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cnt = 0, cmpl_cnt = 0, err_cnt = 0;
  int last_start = 0, last_cmpl = 0, last_err = 0;
  int start_vals[$];
  int exp_fill[6] = '{8, 3, 1, 4, 2, 6};
  bit hang = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.start_o) begin
      start_cnt++;
      start_vals.push_back(int'(bus.cnt_val_o));
      last_start = cyc;
    end
    if (cmpl_o) begin
      cmpl_cnt++;
      last_cmpl = cyc;
    end
    if (err_o) begin
      err_cnt++;
      last_err = cyc;
    end
  end

  // responder: run for V cycles after start, then a one-cycle done (suppressed when hang)
  initial begin
    int  rcnt;
    bit  ractive;
    rcnt = 0;
    ractive = 1'b0;
    bus.run_i = 1'b0;
    bus.done_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.done_i = 1'b0;
      if (rst) begin
        ractive = 1'b0;
        bus.run_i = 1'b0;
      end else if (ractive) begin
        if (rcnt > 0) begin
          bus.run_i = 1'b1;
          rcnt--;
        end else begin
          bus.run_i = 1'b0;
          if (!hang) bus.done_i = 1'b1;
          ractive = 1'b0;
        end
      end else if (bus.start_o) begin
        ractive = 1'b1;
        rcnt = int'(bus.cnt_val_o);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [W-1:0] v, output int waited);
    waited = 0;
    bus.job_valid_i = 1'b1;
    bus.job_val_i = v;
    while (!bus.job_ready_o && waited < 200) begin
      tick();
      waited++;
    end
    `CHK("push_accept", bus.job_ready_o, 1'b1)
    tick();
    bus.job_valid_i = 1'b0;
  endtask

  task automatic wait_cmpl(input int target);
    int n = 0;
    while (cmpl_cnt < target && n < 300) begin
      tick();
      n++;
    end
    `CHK("wait_cmpl", cmpl_cnt >= target, 1'b1)
  endtask

  task automatic wait_err(input int target);
    int n = 0;
    while (err_cnt < target && n < 300) begin
      tick();
      n++;
    end
    `CHK("wait_err", err_cnt >= target, 1'b1)
  endtask

  initial begin
    int w, s0, c0, e0;
    bus.job_valid_i = 1'b0;
    bus.job_val_i = '0;
    rst = 1'b1;
    tick(2);

    `CHK("rst_start", bus.start_o, 1'b0)
    `CHK("rst_busy", busy_o, 1'b0)
    `CHK("rst_cmpl", cmpl_o, 1'b0)
    `CHK("rst_err", err_o, 1'b0)
    `CHK("rst_cnt_val", bus.cnt_val_o, 7'd0)
    `CHK("rst_jobs_done", jobs_done_o, 16'd0)
    `CHK("rst_ready", bus.job_ready_o, 1'b1)
    rst = 1'b0;
    tick(2);

    // single job of 5: start two cycles after accept, cmpl V+2 cycles after start
    s0 = start_cnt;
    c0 = cmpl_cnt;
    bus.job_valid_i = 1'b1;
    bus.job_val_i = 7'd5;
    tick();
    bus.job_valid_i = 1'b0;
    `CHK("single_no_start_yet", bus.start_o, 1'b0)
    tick();
    `CHK("single_start", bus.start_o, 1'b1)
    `CHK("single_cnt_val", bus.cnt_val_o, 7'd5)
    `CHK("single_busy", busy_o, 1'b1)
    tick();
    `CHK("single_start_pulse", bus.start_o, 1'b0)
    wait_cmpl(c0 + 1);
    `CHK("single_latency", last_cmpl - last_start, 7)
    `CHK("single_starts", start_cnt - s0, 1)
    `CHK("single_jobs_done", jobs_done_o, 16'd1)
    tick();
    `CHK("single_idle", busy_o, 1'b0)

    // fill: one job in flight, four queued, fifth held until a slot frees
    s0 = start_cnt;
    c0 = cmpl_cnt;
    push(7'd8, w);
    push(7'd3, w);
    push(7'd1, w);
    push(7'd4, w);
    push(7'd2, w);
    `CHK("fill_full_ready", bus.job_ready_o, 1'b0)
    push(7'd6, w);
    `CHK("fill_held_cycles", w, 8)
    wait_cmpl(c0 + 6);
    `CHK("fill_starts", start_cnt - s0, 6)
    for (int i = 0; i < 6; i++) begin
      `CHK("fill_order", start_vals[s0 + i], exp_fill[i])
    end
    `CHK("fill_jobs_done", jobs_done_o, 16'd7)

    // zero-value reject followed by a normal job
    tick(2);
    s0 = start_cnt;
    c0 = cmpl_cnt;
    e0 = err_cnt;
    push(7'd0, w);
    push(7'd3, w);
    wait_cmpl(c0 + 1);
    `CHK("zero_err", err_cnt - e0, 1)
    `CHK("zero_starts", start_cnt - s0, 1)
    `CHK("zero_val", start_vals[s0], 3)
    `CHK("zero_jobs_done", jobs_done_o, 16'd8)

    // watchdog: responder never signals done
    tick(2);
    hang = 1'b1;
    c0 = cmpl_cnt;
    e0 = err_cnt;
    push(7'd5, w);
    wait_err(e0 + 1);
    `CHK("wd_err_time", last_err - last_start, 21)
    `CHK("wd_no_cmpl", cmpl_cnt, c0)
    tick();
    `CHK("wd_idle", busy_o, 1'b0)
    `CHK("wd_jobs_done", jobs_done_o, 16'd8)
    hang = 1'b0;
    tick(3);

    // done arrives in the expiry cycle: completion wins
    e0 = err_cnt;
    c0 = cmpl_cnt;
    push(7'd19, w);
    wait_cmpl(c0 + 1);
    `CHK("exp_cmpl_time", last_cmpl - last_start, 21)
    tick(2);
    `CHK("exp_no_err", err_cnt, e0)
    `CHK("exp_jobs_done", jobs_done_o, 16'd9)

    // reset while in WAIT_DONE with two jobs queued
    push(7'd10, w);
    tick();
    push(7'd2, w);
    push(7'd3, w);
    tick(2);
    `CHK("mid_running", bus.run_i, 1'b1)
    `CHK("mid_busy", busy_o, 1'b1)
    rst = 1'b1;
    #1;
    `CHK("mid_rst_start", bus.start_o, 1'b0)
    `CHK("mid_rst_busy", busy_o, 1'b0)
    `CHK("mid_rst_cmpl", cmpl_o, 1'b0)
    `CHK("mid_rst_err", err_o, 1'b0)
    `CHK("mid_rst_cnt_val", bus.cnt_val_o, 7'd0)
    `CHK("mid_rst_jobs_done", jobs_done_o, 16'd0)
    `CHK("mid_rst_ready", bus.job_ready_o, 1'b1)
    tick(2);
    rst = 1'b0;
    s0 = start_cnt;
    tick(5);
    `CHK("mid_fifo_flushed", start_cnt, s0)
    c0 = cmpl_cnt;
    push(7'd4, w);
    tick();
    `CHK("post_rst_start", bus.start_o, 1'b1)
    `CHK("post_rst_cnt_val", bus.cnt_val_o, 7'd4)
    wait_cmpl(c0 + 1);
    `CHK("post_rst_jobs_done", jobs_done_o, 16'd1)

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
